arcade_key_mapper: RTL and testbench

Parametrised keyboard/joystick input mapper for arcade cores. Decodes the HPS `ps2_key` event word into up to `NUM_KEYS` latched key states using a parameter keycode table, ORs them with the merged joystick word, and rotates the four direction bits for rotated-monitor modes. It also stretches the coin pulse to a guaranteed minimum width. It sits between `hps_io` and the game core and replaces per-core hand-written key `case` blocks.

---
 rtl/arcade_key_mapper.sv | 108 ++++++++++
 tb/tb_arcade_key_mapper.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_key_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : arcade_key_mapper
//  Brief    : Maps HPS ps2_key events onto latched key states, merges them with
//             the joystick word, rotates the directions and stretches the coin.
//  Revision : 1.0 - initial release
// ============================================================================
module arcade_key_mapper #(
    parameter int                    NUM_KEYS     = 8,
    parameter logic [9*NUM_KEYS-1:0] KEYCODES     = '0,
    parameter int                    COIN_IDX     = 7,
    parameter logic [15:0]           COIN_STRETCH = 16'd0
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [64:0]         ps2_key,
    input  logic [NUM_KEYS-1:0] joystick,
    input  logic [1:0]          rot,
    input  logic                key_clear,
    output logic [NUM_KEYS-1:0] keys,
    output logic [NUM_KEYS-1:0] joy_out
);

    localparam bit c_coin_en = (COIN_STRETCH != 16'd0) && (COIN_IDX < NUM_KEYS);

    logic                r_tog_q;
    logic                w_event;
    logic                w_pressed;
    logic                w_ext;
    logic [8:0]          w_code;
    logic [NUM_KEYS-1:0] w_hit;
    logic [NUM_KEYS-1:0] w_merged;
    logic [NUM_KEYS-1:0] w_rot;
    logic [NUM_KEYS-1:0] w_stretch;

    assign w_event   = ps2_key[64] ^ r_tog_q;
    assign w_pressed = (ps2_key[15:8] != 8'hF0);
    // On release the E0 prefix sits one byte further up, behind the F0.
    assign w_ext     = w_pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
    assign w_code    = (|ps2_key[63:24]) ? 9'h000 : {w_ext, ps2_key[7:0]};

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_match
            localparam logic [8:0] c_entry = KEYCODES[9*gi +: 9];
            assign w_hit[gi] = (c_entry != 9'h000) && (c_entry == w_code);
        end
    endgenerate

    always_ff @(posedge clk_sys) begin
        r_tog_q <= ps2_key[64];
        if (reset || key_clear) begin
            keys <= '0;
        end else if (w_event) begin
            keys <= (keys & ~w_hit) | (w_hit & {NUM_KEYS{w_pressed}});
        end
    end

    assign w_merged = keys | joystick;

    always_comb begin
        w_rot = w_merged;
        case (rot)
            2'd1:    w_rot[3:0] = {w_merged[1], w_merged[0], w_merged[2], w_merged[3]};
            2'd2:    w_rot[3:0] = {w_merged[2], w_merged[3], w_merged[0], w_merged[1]};
            2'd3:    w_rot[3:0] = {w_merged[0], w_merged[1], w_merged[3], w_merged[2]};
            default: w_rot[3:0] = w_merged[3:0];
        endcase
    end

    generate
        if (c_coin_en) begin : g_coin
            logic        r_coin_q;
            logic [15:0] r_cnt;
            logic        w_rise;

            assign w_rise = w_merged[COIN_IDX] & ~r_coin_q;

            // Counter holds the remaining extra cycles after the input drops.
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    r_coin_q <= 1'b0;
                    r_cnt    <= 16'd0;
                end else begin
                    r_coin_q <= w_merged[COIN_IDX];
                    if (w_rise) begin
                        r_cnt <= COIN_STRETCH - 16'd1;
                    end else if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
            end

            assign w_stretch = (r_cnt != 16'd0) ? (NUM_KEYS'(1) << COIN_IDX) : '0;
        end else begin : g_no_coin
            assign w_stretch = '0;
        end
    endgenerate

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            joy_out <= '0;
        end else begin
            joy_out <= w_rot | w_stretch;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arcade_key_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arcade_key_mapper
//  Brief    : Self-checking bench: reference model compared every cycle plus
//             directed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arcade_key_mapper;

    localparam int          NK      = 8;
    localparam logic [71:0] KC      = {9'h02E, 9'h01C, 9'h01C, 9'h029,
                                       9'h175, 9'h172, 9'h16B, 9'h174};
    localparam int          STRETCH = 16;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic [64:0]   ps2_key;
    logic [NK-1:0] joystick;
    logic [1:0]    rot;
    logic          key_clear;
    logic [NK-1:0] keys;
    logic [NK-1:0] joy_out;

    int checks = 0;
    int errors = 0;

    arcade_key_mapper #(
        .NUM_KEYS     (NK),
        .KEYCODES     (KC),
        .COIN_IDX     (7),
        .COIN_STRETCH (16'(STRETCH))
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_key   (ps2_key),
        .joystick  (joystick),
        .rot       (rot),
        .key_clear (key_clear),
        .keys      (keys),
        .joy_out   (joy_out)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [8:0]    tbl [NK];
    int            rot_src [16] = '{0,1,2,3, 3,2,0,1, 1,0,3,2, 2,3,1,0};
    logic [NK-1:0] mk, mj;
    logic          mtog, mprev, mvalid = 1'b0;
    int            age;

    initial begin
        for (int i = 0; i < NK; i++) tbl[i] = KC[9*i +: 9];
    end

    initial begin
        logic [NK-1:0] m, nj;
        logic          rel, ext;
        logic [8:0]    code;
        forever begin
            @(posedge clk_sys);
            if (reset) begin
                mk = '0; mj = '0; mtog = ps2_key[64]; mprev = 1'b0; age = 1000;
            end else begin
                m = mk | joystick;
                nj = m;
                for (int d = 0; d < 4; d++) nj[d] = m[rot_src[int'(rot)*4 + d]];
                if (m[7] && !mprev) age = 0;
                else if (age < 1000) age++;
                nj[7] = m[7] | (age >= 1 && age <= STRETCH - 1);
                mprev = m[7];
                mj = nj;
                if (key_clear) begin
                    mk = '0;
                end else if (ps2_key[64] != mtog && ps2_key[63:24] == 40'h0) begin
                    rel  = (ps2_key[15:8] == 8'hF0);
                    ext  = rel ? (ps2_key[23:16] == 8'hE0) : (ps2_key[15:8] == 8'hE0);
                    code = {ext, ps2_key[7:0]};
                    for (int i = 0; i < NK; i++)
                        if (code != 9'h000 && tbl[i] == code) mk[i] = !rel;
                end
                mtog = ps2_key[64];
            end
            mvalid = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk_sys);
            if (mvalid) begin
                chk("model_keys", 32'(keys), 32'(mk));
                chk("model_joy_out", 32'(joy_out), 32'(mj));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic ev(input logic [39:0] hi, input logic [23:0] lo);
        ps2_key = {~ps2_key[64], hi, lo};
        @(negedge clk_sys);
    endtask

    logic [3:0] rot_exp [4] = '{4'b1000, 4'b0001, 4'b0100, 4'b0010};
    int         cnt;

    initial begin
        reset = 1'b1; ps2_key = '0; joystick = '0; rot = 2'd0; key_clear = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("reset_keys", 32'(keys), 32'h0);
        chk("reset_joy", 32'(joy_out), 32'h0);

        // Press / release space
        ev(40'h0, 24'h000029);
        chk("space_press_key", 32'(keys[4]), 32'h1);
        chk("space_press_joy_lag", 32'(joy_out[4]), 32'h0);
        @(negedge clk_sys);
        chk("space_press_joy", 32'(joy_out[4]), 32'h1);
        ev(40'h0, 24'h00F029);
        chk("space_release_key", 32'(keys[4]), 32'h0);
        @(negedge clk_sys);
        chk("space_release_joy", 32'(joy_out[4]), 32'h0);

        // Extended vs plain, and PRNSCR/PAUSE filter
        ev(40'h0, 24'h000074);
        chk("plain_74_ignored", 32'(keys), 32'h0);
        ev(40'h0, 24'h00E074);
        chk("ext_74_press", 32'(keys), 32'h01);
        ev(40'h0000000001, 24'hE0F074);
        chk("long_event_ignored", 32'(keys), 32'h01);
        ev(40'h0, 24'hE0F074);
        chk("ext_74_release", 32'(keys), 32'h0);

        // Rotation of a held "up"
        ev(40'h0, 24'h00E075);
        chk("up_press", 32'(keys), 32'h08);
        for (int r = 0; r < 4; r++) begin
            rot = 2'(r);
            @(negedge clk_sys);
            chk($sformatf("rot%0d_up", r), 32'(joy_out[3:0]), 32'(rot_exp[r]));
        end
        ev(40'h0, 24'hE0F075);
        rot = 2'd1; joystick = 8'h02;
        @(negedge clk_sys);
        chk("rot1_joy_left", 32'(joy_out[3:0]), 32'h8);
        joystick = '0; rot = 2'd0;
        repeat (2) @(negedge clk_sys);

        // Coin stretch: single pulse
        joystick = 8'h80;
        @(negedge clk_sys);
        cnt = joy_out[7] ? 1 : 0;
        joystick = '0;
        repeat (25) begin
            @(negedge clk_sys);
            if (joy_out[7]) cnt++;
        end
        chk("coin_single_width", 32'(cnt), 32'd16);

        // Coin stretch: retrigger at cycle 10
        joystick = 8'h80;
        @(negedge clk_sys);
        cnt = joy_out[7] ? 1 : 0;
        joystick = '0;
        repeat (9) begin
            @(negedge clk_sys);
            if (joy_out[7]) cnt++;
        end
        joystick = 8'h80;
        @(negedge clk_sys);
        if (joy_out[7]) cnt++;
        joystick = '0;
        repeat (30) begin
            @(negedge clk_sys);
            if (joy_out[7]) cnt++;
        end
        chk("coin_retrigger_width", 32'(cnt), 32'd26);

        // Clear collides with a press
        key_clear = 1'b1;
        ev(40'h0, 24'h000029);
        key_clear = 1'b0;
        chk("clear_collision", 32'(keys), 32'h0);
        repeat (2) @(negedge clk_sys);
        chk("clear_event_consumed", 32'(keys), 32'h0);

        // Reset mid-hold, toggle during reset lost
        ev(40'h0, 24'h000029);
        @(negedge clk_sys);
        chk("hold_before_reset", 32'(joy_out), 32'h10);
        reset = 1'b1;
        ev(40'h0, 24'h00001C);
        chk("reset_mid_keys", 32'(keys), 32'h0);
        chk("reset_mid_joy", 32'(joy_out), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("reset_toggle_lost", 32'(keys), 32'h0);

        // First toggle after reset; duplicate table entries
        ev(40'h0, 24'h00001C);
        chk("dup_press", 32'(keys), 32'h60);
        ev(40'h0, 24'h00F01C);
        chk("dup_release", 32'(keys), 32'h0);

        // Back-to-back press and release
        ev(40'h0, 24'h000029);
        chk("b2b_high", 32'(keys), 32'h10);
        ev(40'h0, 24'h00F029);
        chk("b2b_final", 32'(keys), 32'h0);
        repeat (2) @(negedge clk_sys);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
